rv_instr_encoder: RTL

//  Inverse of the control-unit decode path: accepts RV32I instruction fields over a valid/ready

---
 rtl/rv_enc_pkg.sv | 35 +++
 rtl/rv_instr_pack.sv | 37 +++
 rtl/rv_instr_encoder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rv_enc_pkg.sv
// rtl/rv_enc_pkg.sv - shared opcode constants, format/state enums and opcode classifier for the RV32I encoder
package rv_enc_pkg;

    typedef enum logic [2:0] {FMT_U, FMT_J, FMT_I, FMT_ISH, FMT_R, FMT_B, FMT_S, FMT_BAD} fmt_e;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

    localparam logic [2:0] FNC_SLL = 3'b001;
    localparam logic [2:0] FNC_SR  = 3'b101;

    function automatic fmt_e opc_to_fmt(input logic [6:0] opc, input logic [2:0] func3);
        fmt_e f;
        case (opc)
            OPC_LUI, OPC_AUIPC: f = FMT_U;
            OPC_JAL:            f = FMT_J;
            OPC_JALR, OPC_LOAD: f = FMT_I;
            OPC_ARI_ITYPE:      f = (func3 == FNC_SLL || func3 == FNC_SR) ? FMT_ISH : FMT_I;
            OPC_ARI_RTYPE:      f = FMT_R;
            OPC_BRANCH:         f = FMT_B;
            OPC_STORE:          f = FMT_S;
            default:            f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// rtl/rv_instr_pack.sv - combinational packing of RV32I instruction fields into a 32-bit word
module rv_instr_pack
    import rv_enc_pkg::*;
(
    input  logic [6:0]  opc,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  func3,
    input  logic        func1,
    input  logic [31:0] imm,
    output fmt_e        fmt,
    output logic [31:0] word
);

    logic [2:0] f3_eff;
    logic       unused_imm_lsb;

    // B/J offsets are always even, so bit 0 carries no information
    assign unused_imm_lsb = imm[0];

    always_comb begin
        fmt    = opc_to_fmt(opc, func3);
        f3_eff = (opc == OPC_JALR) ? 3'b000 : func3;
        case (fmt)
            FMT_U:   word = {imm[31:12], rd, opc};
            FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            FMT_I:   word = {imm[11:0], rs1, f3_eff, rd, opc};
            FMT_ISH: word = {1'b0, func1, 5'b00000, imm[4:0], rs1, func3, rd, opc};
            FMT_R:   word = {1'b0, func1, 5'b00000, rs2, rs1, func3, rd, opc};
            FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opc};
            FMT_S:   word = {imm[11:5], rs2, rs1, func3, imm[4:0], opc};
            default: word = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// rtl/rv_instr_encoder.sv - handshake-driven RV32I program loader writing encoded words into IMEM
module rv_instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opc,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_func3,
    input  logic              in_func1,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_ovf,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_ill_q, err_ill_d;
    logic                err_ovf_q, err_ovf_d;
    fmt_e                fmt;
    logic [31:0]         word;
    logic                accept;

    rv_instr_pack u_pack (
        .opc   (in_opc),
        .rd    (in_rd),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .func3 (in_func3),
        .func1 (in_func1),
        .imm   (in_imm),
        .fmt   (fmt),
        .word  (word)
    );

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= BASE;
            count_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= BASE;
            wdata_q   <= '0;
            err_ill_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_ill_q <= err_ill_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (err_ovf_q || (accept && in_last)) state_d = DONE;
            DONE:    if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == LOAD);
        done     = (state_q == DONE);
        in_ready = (state_q == LOAD) && !err_ovf_q;
    end

    // Illegal opcodes complete the handshake but leave pointer/count untouched
    always_comb begin
        ptr_d     = ptr_q;
        count_d   = count_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_ill_d = err_ill_q;
        err_ovf_d = err_ovf_q;
        if (state_q != LOAD && start) begin
            ptr_d     = BASE;
            count_d   = '0;
            err_ill_d = 1'b0;
            err_ovf_d = 1'b0;
        end else if (accept) begin
            if (fmt == FMT_BAD) begin
                err_ill_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = word;
                count_d = count_q + (ADDR_W + 1)'(1);
                if (ptr_q == LAST) err_ovf_d = 1'b1;
                else               ptr_d = ptr_q + ADDR_W'(1);
            end
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign err_illegal = err_ill_q;
    assign err_ovf     = err_ovf_q;
    assign count       = count_q;

endmodule
